// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad configuration shift chain.
// Optional chain reset is enabled with GPIO_SHIFT_CHAIN_RESET_EN.
package gpio_cfg_pkg;

    localparam int CFG_BITS = 13;

    typedef enum logic [2:0] {
        IDLE,
        CHAIN_RST,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_e;

    // Field positions inside one per-pad configuration word
    localparam int MGMT_EN_BIT     = 0;
    localparam int OEB_BIT         = 1;
    localparam int HOLDOVER_BIT    = 2;
    localparam int INP_DIS_BIT     = 3;
    localparam int IB_MODE_SEL_BIT = 4;
    localparam int ANALOG_EN_BIT   = 5;
    localparam int ANALOG_SEL_BIT  = 6;
    localparam int ANALOG_POL_BIT  = 7;
    localparam int SLOW_BIT        = 8;
    localparam int VTRIP_BIT       = 9;
    localparam int DM_LSB          = 10;
    localparam int DM_MSB          = 12;

endpackage

// File: rtl/gpio_shift_tick.sv
// Phase counter for the serial chain: pulses phase_end every CLK_DIV cycles
// and restarts whenever the controlling FSM changes state.
module gpio_shift_tick #(
    parameter int CLK_DIV = 4,
    localparam int CNT_W  = $clog2(CLK_DIV + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic phase_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign phase_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || phase_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_config_shifter.sv
// Loads one configuration word per pad into the GPIO control daisy chain, MSB-first,
// farthest pad first, then latches. GPIO_SHIFT_CHAIN_RESET_EN adds a chain reset phase.
module gpio_config_shifter #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = gpio_cfg_pkg::CFG_BITS,
    parameter int CLK_DIV  = 4,
    localparam int IDX_W   = $clog2(NUM_PADS),
    localparam int BIT_W   = $clog2(CFG_BITS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    cfg_idx,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_out
);

    import gpio_cfg_pkg::*;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CFG_BITS-1:0] shift_q, shift_d;
    logic                sdo_q, sdo_d;
    logic                phase_end;
    logic                restart;

    assign restart = (state_d != state_q);

    gpio_shift_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .resetn   (resetn),
        .restart  (restart),
        .phase_end(phase_end)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sdo_d   = sdo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d = IDX_W'(NUM_PADS - 1);
`ifdef GPIO_SHIFT_CHAIN_RESET_EN
                    state_d = CHAIN_RST;
`else
                    state_d = LOAD;
`endif
                end
            end
            CHAIN_RST: begin
                if (phase_end) state_d = LOAD;
            end
            LOAD: begin
                shift_d = cfg_data;
                bit_d   = BIT_W'(CFG_BITS - 1);
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (phase_end) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    shift_d = shift_q << 1;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - 1'b1;
                        state_d = SHIFT_LO;
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase_end) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Data only moves as the low phase begins, keeping it stable across the high phase
        if (state_d == SHIFT_LO && state_q != SHIFT_LO) begin
            sdo_d = shift_d[CFG_BITS-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sdo_q   <= sdo_d;
        end
    end

    assign busy            = (state_q != IDLE) && (state_q != DONE);
    assign done            = (state_q == DONE);
    assign cfg_idx         = idx_q;
    assign serial_clock    = (state_q == SHIFT_HI);
    assign serial_load     = (state_q == LATCH);
    assign serial_data_out = sdo_q;

`ifdef GPIO_SHIFT_CHAIN_RESET_EN
    assign serial_resetn = (state_q != CHAIN_RST);
`else
    assign serial_resetn = 1'b1;
`endif

endmodule

// File: tb/tb_gpio_config_shifter.sv
// Scoreboard bench for gpio_config_shifter: expected chain bits are queued at start
// and popped at each serial_clock rising edge; transfer-level timing is counted alongside.
module tb_gpio_config_shifter;

    localparam int NP = 3;
    localparam int CB = 13;
    localparam int CD = 3;
`ifdef GPIO_SHIFT_CHAIN_RESET_EN
    localparam int RST_CYC = CD;
`else
    localparam int RST_CYC = 0;
`endif
    localparam int BUSY_EXP = NP * (1 + 2 * CB * CD) + CD + RST_CYC;
    localparam int IDX_W    = $clog2(NP);

    logic             clk;
    logic             resetn;
    logic             start;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] cfg_idx;
    logic [CB-1:0]    cfg_data;
    logic             serial_clock;
    logic             serial_load;
    logic             serial_resetn;
    logic             serial_data_out;

    logic [CB-1:0] mem [NP];

    int check_count;
    int err_count;
    bit exp_q [$];

    int rise_cnt, busy_cycles, done_cycles, load_cycles, load_pulses, overlap;
    int bad_hi, bad_lo, unstable, rst_low, rst_before, done_busy;
    int hi_run, lo_run;
    logic prev_sclk, prev_load, held_bit;

    gpio_config_shifter #(
        .NUM_PADS(NP),
        .CFG_BITS(CB),
        .CLK_DIV (CD)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .cfg_idx        (cfg_idx),
        .cfg_data       (cfg_data),
        .serial_clock   (serial_clock),
        .serial_load    (serial_load),
        .serial_resetn  (serial_resetn),
        .serial_data_out(serial_data_out)
    );

    assign cfg_data = (int'(cfg_idx) < NP) ? mem[cfg_idx] : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic clearStats();
        rise_cnt    = 0;
        busy_cycles = 0;
        done_cycles = 0;
        load_cycles = 0;
        load_pulses = 0;
        overlap     = 0;
        bad_hi      = 0;
        bad_lo      = 0;
        unstable    = 0;
        rst_low     = 0;
        rst_before  = 0;
        done_busy   = 0;
    endtask

    task automatic pushExpected();
        logic [CB-1:0] w;
        for (int p = NP - 1; p >= 0; p--) begin
            w = mem[p];
            for (int b = CB - 1; b >= 0; b--) exp_q.push_back(w[b]);
        end
    endtask

    // Monitor: samples on the falling clk edge, away from the DUT's update edge
    initial begin
        prev_sclk = 1'b0;
        prev_load = 1'b0;
        held_bit  = 1'b0;
        hi_run    = 0;
        lo_run    = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) done_cycles++;
            if (done === 1'b1 && busy === 1'b1) done_busy++;
            if (serial_load === 1'b1) load_cycles++;
            if (serial_load === 1'b1 && prev_load !== 1'b1) load_pulses++;
            if (serial_load === 1'b1 && serial_clock === 1'b1) overlap++;
            if (serial_resetn === 1'b0) begin
                rst_low++;
                if (rise_cnt == 0) rst_before++;
            end
            if (serial_clock === 1'b1) begin
                if (prev_sclk !== 1'b1) begin
                    if (rise_cnt > 0 && (lo_run < CD || lo_run > CD + 1)) bad_lo++;
                    rise_cnt++;
                    held_bit = serial_data_out;
                    hi_run   = 1;
                    lo_run   = 0;
                    if (exp_q.size() == 0) checkOutput("sdo_extra_edge", exp_q.size(), 1);
                    else checkOutput("sdo_bit", serial_data_out, exp_q.pop_front());
                end else begin
                    hi_run++;
                    if (serial_data_out !== held_bit) unstable++;
                end
            end else begin
                if (prev_sclk === 1'b1 && hi_run != CD) bad_hi++;
                lo_run++;
            end
            prev_sclk = serial_clock;
            prev_load = serial_load;
        end
    end

    task automatic applyStimulus(input bit noisy);
        int cyc;
        bit got_done;
        clearStats();
        pushExpected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_rise", busy, 1);
        checkOutput("idx_start", cfg_idx, NP - 1);
        cyc      = 0;
        got_done = 1'b0;
        while (cyc < BUSY_EXP + 20) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            start = noisy && (cyc % 17 == 4);
            @(negedge clk);
            cyc++;
        end
        checkOutput("done_seen", got_done, 1);
        checkOutput("busy_at_done", busy, 0);
        start = noisy;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * CD + 6) @(negedge clk);
        checkOutput("busy_cycles", busy_cycles, BUSY_EXP);
        checkOutput("done_cycles", done_cycles, 1);
        checkOutput("done_busy_overlap", done_busy, 0);
        checkOutput("rise_count", rise_cnt, NP * CB);
        checkOutput("load_cycles", load_cycles, CD);
        checkOutput("load_pulses", load_pulses, 1);
        checkOutput("load_clk_overlap", overlap, 0);
        checkOutput("sclk_high_width", bad_hi, 0);
        checkOutput("sclk_low_width", bad_lo, 0);
        checkOutput("sdo_unstable", unstable, 0);
        checkOutput("chain_rst_cycles", rst_low, RST_CYC);
        checkOutput("chain_rst_before_clk", rst_before, RST_CYC);
        checkOutput("queue_left", exp_q.size(), 0);
        checkOutput("idx_end", cfg_idx, 0);
        exp_q.delete();
    endtask

    initial begin
        check_count = 0;
        err_count   = 0;
        resetn      = 1'b0;
        start       = 1'b0;
        mem[0]      = 13'h1555;
        mem[1]      = 13'h0403;
        mem[2]      = 13'h1ABC;
        clearStats();
        repeat (3) @(negedge clk);
        checkOutput("rst_flags", {busy, done, serial_clock, serial_load, serial_resetn, serial_data_out}, 6'b000010);
        checkOutput("rst_idx", cfg_idx, 0);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] transfer 1: fixed words");
        applyStimulus(1'b0);

        $display("[TB] transfer 2: extra start pulses while busy and during done");
        mem[0] = 13'h0FFF;
        mem[1] = 13'h1000;
        mem[2] = 13'h0A5A;
        applyStimulus(1'b1);

        $display("[TB] reset in the middle of a transfer");
        clearStats();
        pushExpected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (BUSY_EXP / 2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_flags", {busy, done, serial_clock, serial_load, serial_resetn, serial_data_out}, 6'b000010);
        checkOutput("midrst_idx", cfg_idx, 0);
        checkOutput("midrst_no_load", load_pulses, 0);
        exp_q.delete();
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] transfer 3: random words after reset");
        for (int p = 0; p < NP; p++) mem[p] = CB'($urandom);
        applyStimulus(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
        $finish;
    end

endmodule
